// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 scancode consumer.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT
    } state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scancode to ASCII lookup for letters, digits and space.
// Unmapped codes return 8'h00; 'upper' selects capital letters.
module ps2_scan2ascii (
    input  logic [7:0] scancode,
    input  logic       upper,
    output logic [7:0] ascii
);

    logic [7:0] base;
    logic       letter;

    always_comb begin
        base = 8'h00;
        case (scancode)
            8'h1C: base = 8'h61; // a
            8'h32: base = 8'h62;
            8'h21: base = 8'h63;
            8'h23: base = 8'h64;
            8'h24: base = 8'h65;
            8'h2B: base = 8'h66;
            8'h34: base = 8'h67;
            8'h33: base = 8'h68;
            8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;
            8'h42: base = 8'h6B;
            8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;
            8'h31: base = 8'h6E;
            8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;
            8'h15: base = 8'h71;
            8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;
            8'h2C: base = 8'h74;
            8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;
            8'h1D: base = 8'h77;
            8'h22: base = 8'h78;
            8'h35: base = 8'h79;
            8'h1A: base = 8'h7A; // z
            8'h45: base = 8'h30; // 0
            8'h16: base = 8'h31;
            8'h1E: base = 8'h32;
            8'h26: base = 8'h33;
            8'h25: base = 8'h34;
            8'h2E: base = 8'h35;
            8'h36: base = 8'h36;
            8'h3D: base = 8'h37;
            8'h3E: base = 8'h38;
            8'h46: base = 8'h39; // 9
            8'h29: base = 8'h20; // space
            default: base = 8'h00;
        endcase
        letter = (base >= 8'h61) && (base <= 8'h7A);
        ascii  = (upper && letter) ? (base - 8'h20) : base;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops scancodes from the ps2_keyboard FIFO, tracks the single held key and counts presses.
// Optional SHIFT_CASE_EN: shift keys only set a case flag and letters map to upper case.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       scancode,
    output logic             key_ext,
    output logic [7:0]       ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_seen
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_next;
    logic [7:0]  byte_r;
    logic        brk, ext;
    logic        vld_p1;
    logic [7:0]  code_p1;
    logic        ext_p1, brk_p1;
    logic        same_key, shift_key, key_act;
    logic        upper;
    logic [7:0]  rom_ascii;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (kb_ready) state_next = S_POP;
            S_POP:   state_next = S_WAIT;
            S_WAIT:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pop strobe is registered: low exactly for the S_POP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            nextdata_n <= 1'b1;
            byte_r     <= 8'h00;
        end else begin
            state      <= state_next;
            nextdata_n <= (state_next != S_POP);
            if (state == S_IDLE && kb_ready)
                byte_r <= kb_data;
        end
    end

    // Stage p1: prefix parsing of the popped byte; a complete code is handed on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk     <= 1'b0;
            ext     <= 1'b0;
            vld_p1  <= 1'b0;
            code_p1 <= 8'h00;
            ext_p1  <= 1'b0;
            brk_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (state == S_POP) begin
                if (byte_r == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (byte_r == PS2_EXT) begin
                    ext <= 1'b1;
                end else begin
                    vld_p1  <= 1'b1;
                    code_p1 <= byte_r;
                    ext_p1  <= ext;
                    brk_p1  <= brk;
                    brk     <= 1'b0;
                    ext     <= 1'b0;
                end
            end
        end
    end

    assign same_key = key_valid && (scancode == code_p1) && (key_ext == ext_p1);

`ifdef SHIFT_CASE_EN
    logic shift_held;

    assign shift_key = !ext_p1 && ((code_p1 == PS2_LSHIFT) || (code_p1 == PS2_RSHIFT));
    assign upper     = shift_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shift_held <= 1'b0;
        else if (vld_p1 && shift_key)
            shift_held <= !brk_p1;
    end
`else
    assign shift_key = 1'b0;
    assign upper     = 1'b0;
`endif

    assign key_act = vld_p1 && !shift_key;

    // Stage p2: commit make/release against the held key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            scancode  <= 8'h00;
            key_ext   <= 1'b0;
            press_cnt <= '0;
            ovf_seen  <= 1'b0;
        end else begin
            if (kb_overflow)
                ovf_seen <= 1'b1;
            if (key_act) begin
                if (brk_p1) begin
                    if (same_key)
                        key_valid <= 1'b0;
                end else if (!same_key) begin
                    scancode  <= code_p1;
                    key_ext   <= ext_p1;
                    key_valid <= 1'b1;
                    press_cnt <= press_cnt + CNT_ONE;
                end
            end
        end
    end

    ps2_scan2ascii u_rom (
        .scancode (scancode),
        .upper    (upper),
        .ascii    (rom_ascii)
    );

    assign ascii = (key_valid && !key_ext) ? rom_ascii : 8'h00;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: drives the FIFO handshake byte by byte.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] scancode;
    logic       key_ext;
    logic [7:0] ascii;
    logic [7:0] press_cnt;
    logic       ovf_seen;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int viol = 0;

    always #5 clk = ~clk;

    ps2_key_tracker #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .kb_data     (kb_data),
        .kb_ready    (kb_ready),
        .kb_overflow (kb_overflow),
        .nextdata_n  (nextdata_n),
        .key_valid   (key_valid),
        .scancode    (scancode),
        .key_ext     (key_ext),
        .ascii       (ascii),
        .press_cnt   (press_cnt),
        .ovf_seen    (ovf_seen)
    );

    always @(negedge clk) begin
        if (nextdata_n === 1'b0 && kb_ready === 1'b0)
            viol++;
    end

    task automatic do_reset();
        @(negedge clk);
        kb_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        kb_data  = b;
        kb_ready = 1'b1;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL pop_timeout byte=%h: nextdata_n never went low", b);
            kb_ready = 1'b0;
            return;
        end
        pulses++;
        @(posedge clk);
        #1 kb_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (nextdata_n !== 1'b1) begin
            fails++;
            $display("FAIL pop_width byte=%h: nextdata_n=%b required 1", b, nextdata_n);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (nextdata_n !== 1'b1) begin fails++; $display("FAIL reset_nextdata_n got=%b exp=1", nextdata_n); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid got=%b exp=0", key_valid); end
        tests++; if (scancode !== 8'h00) begin fails++; $display("FAIL reset_scancode got=%h exp=00", scancode); end
        tests++; if (key_ext !== 1'b0) begin fails++; $display("FAIL reset_key_ext got=%b exp=0", key_ext); end
        tests++; if (ascii !== 8'h00) begin fails++; $display("FAIL reset_ascii got=%h exp=00", ascii); end
        tests++; if (press_cnt !== 8'h00) begin fails++; $display("FAIL reset_press_cnt got=%h exp=00", press_cnt); end
        tests++; if (ovf_seen !== 1'b0) begin fails++; $display("FAIL reset_ovf_seen got=%b exp=0", ovf_seen); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_make_break();
        do_reset();
        send_byte(8'h1C); settle();
        tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL mb_held_valid got=%b exp=1", key_valid); end
        tests++; if (scancode !== 8'h1C) begin fails++; $display("FAIL mb_scancode got=%h exp=1c", scancode); end
        tests++; if (ascii !== 8'h61) begin fails++; $display("FAIL mb_ascii got=%h exp=61", ascii); end
        tests++; if (press_cnt !== 8'd1) begin fails++; $display("FAIL mb_cnt_held got=%0d exp=1", press_cnt); end
        send_byte(8'hF0); send_byte(8'h1C); settle();
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL mb_released got=%b exp=0", key_valid); end
        tests++; if (ascii !== 8'h00) begin fails++; $display("FAIL mb_ascii_rel got=%h exp=00", ascii); end
        tests++; if (press_cnt !== 8'd1) begin fails++; $display("FAIL mb_cnt_rel got=%0d exp=1", press_cnt); end
    endtask

    task automatic test_typematic();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'h1C);
        settle();
        tests++; if (press_cnt !== 8'd1) begin fails++; $display("FAIL typ_cnt_held got=%0d exp=1", press_cnt); end
        send_byte(8'hF0); send_byte(8'h1C); settle();
        tests++; if (press_cnt !== 8'd1) begin fails++; $display("FAIL typ_cnt got=%0d exp=1", press_cnt); end
        tests++; if (pulses != 7) begin fails++; $display("FAIL typ_pulses got=%0d exp=7", pulses); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL typ_released got=%b exp=0", key_valid); end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0); send_byte(8'h75); settle();
        tests++; if (scancode !== 8'h75) begin fails++; $display("FAIL ext_scancode got=%h exp=75", scancode); end
        tests++; if (key_ext !== 1'b1) begin fails++; $display("FAIL ext_flag got=%b exp=1", key_ext); end
        tests++; if (ascii !== 8'h00) begin fails++; $display("FAIL ext_ascii got=%h exp=00", ascii); end
        tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL ext_valid got=%b exp=1", key_valid); end
        send_byte(8'h75); settle();
        tests++; if (press_cnt !== 8'd2) begin fails++; $display("FAIL ext_plain_distinct got=%0d exp=2", press_cnt); end
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); settle();
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL ext_release got=%b exp=0", key_valid); end
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75); settle();
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL ext_release_swapped got=%b exp=0", key_valid); end
        tests++; if (press_cnt !== 8'd4) begin fails++; $display("FAIL ext_cnt got=%0d exp=4", press_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h16);
            if (i == 0) begin
                settle();
                tests++; if (ascii !== 8'h31) begin fails++; $display("FAIL wrap_ascii got=%h exp=31", ascii); end
            end
            send_byte(8'hF0); send_byte(8'h16);
            if (i == 254) begin
                settle();
                tests++; if (press_cnt !== 8'hFF) begin fails++; $display("FAIL wrap_cnt_ff got=%h exp=ff", press_cnt); end
            end
        end
        settle();
        tests++; if (press_cnt !== 8'h00) begin fails++; $display("FAIL wrap_cnt got=%h exp=00", press_cnt); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL wrap_released got=%b exp=0", key_valid); end
    endtask

    task automatic test_foreign_release();
        do_reset();
        send_byte(8'h32); send_byte(8'hF0); send_byte(8'h1C); settle();
        tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL fr_valid got=%b exp=1", key_valid); end
        tests++; if (scancode !== 8'h32) begin fails++; $display("FAIL fr_scancode got=%h exp=32", scancode); end
        tests++; if (ascii !== 8'h62) begin fails++; $display("FAIL fr_ascii got=%h exp=62", ascii); end
        send_byte(8'h1C); settle();
        tests++; if (press_cnt !== 8'd2) begin fails++; $display("FAIL fr_brk_cleared got=%0d exp=2", press_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk); kb_overflow = 1'b1;
        @(negedge clk); kb_overflow = 1'b0;
        tests++; if (ovf_seen !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", ovf_seen); end
        repeat (5) @(negedge clk);
        tests++; if (ovf_seen !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", ovf_seen); end
        do_reset();
        tests++; if (ovf_seen !== 1'b0) begin fails++; $display("FAIL ovf_cleared got=%b exp=0", ovf_seen); end
    endtask

    task automatic test_reset_mid_pop();
        do_reset();
        send_byte(8'h32); settle();
        @(negedge clk); kb_data = 8'h1C; kb_ready = 1'b1;
        @(negedge clk);
        tests++; if (nextdata_n !== 1'b0) begin fails++; $display("FAIL rp_in_pop got=%b exp=0", nextdata_n); end
        #2 rst = 1'b1;
        #1;
        tests++; if (nextdata_n !== 1'b1) begin fails++; $display("FAIL rp_nextdata_n got=%b exp=1", nextdata_n); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rp_key_valid got=%b exp=0", key_valid); end
        tests++; if (scancode !== 8'h00) begin fails++; $display("FAIL rp_scancode got=%h exp=00", scancode); end
        tests++; if (press_cnt !== 8'h00) begin fails++; $display("FAIL rp_press_cnt got=%h exp=00", press_cnt); end
        @(negedge clk); kb_ready = 1'b0; rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (key_valid !== 1'b0 || press_cnt !== 8'h00) begin
            fails++; $display("FAIL rp_aborted valid=%b cnt=%0d exp valid=0 cnt=0", key_valid, press_cnt);
        end
    endtask

    task automatic test_shift();
        do_reset();
`ifdef SHIFT_CASE_EN
        send_byte(8'h12); send_byte(8'h1C); settle();
        tests++; if (ascii !== 8'h41) begin fails++; $display("FAIL sh_upper got=%h exp=41", ascii); end
        tests++; if (press_cnt !== 8'd1) begin fails++; $display("FAIL sh_cnt got=%0d exp=1", press_cnt); end
        tests++; if (scancode !== 8'h1C) begin fails++; $display("FAIL sh_scancode got=%h exp=1c", scancode); end
        send_byte(8'hF0); send_byte(8'h12); settle();
        tests++; if (ascii !== 8'h61) begin fails++; $display("FAIL sh_lower got=%h exp=61", ascii); end
`else
        send_byte(8'h12); settle();
        tests++; if (scancode !== 8'h12) begin fails++; $display("FAIL sh_plain_scancode got=%h exp=12", scancode); end
        tests++; if (ascii !== 8'h00) begin fails++; $display("FAIL sh_plain_ascii got=%h exp=00", ascii); end
        send_byte(8'h1C); settle();
        tests++; if (ascii !== 8'h61) begin fails++; $display("FAIL sh_lower got=%h exp=61", ascii); end
        tests++; if (press_cnt !== 8'd2) begin fails++; $display("FAIL sh_plain_cnt got=%0d exp=2", press_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_wrap();
        test_foreign_release();
        test_overflow();
        test_reset_mid_pop();
        test_shift();
        tests++;
        if (viol != 0) begin fails++; $display("FAIL pop_without_ready got=%0d exp=0", viol); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
